// File: rtl/rom_axi_burst_rd_slave_pkg.sv
// Shared AXI encodings and helpers for the ROM read slave.
// Also holds the FSM state type used by the top level.
package rom_axi_burst_rd_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B = 3'b010;

    // A wrapping burst needs a power-of-two beat count of at least two.
    function automatic logic wrap_len_ok(input logic [15:0] len);
        return (len != 16'd0) && ((len & (len + 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/rom_axi_burst_rd_slave_rd_beat_fifo.sv
// Two-entry beat buffer {data,resp,last}; push and pop may happen in the same cycle.
// The head entry is presented combinationally.
module rom_axi_burst_rd_slave_rd_beat_fifo
    import rom_axi_burst_rd_slave_pkg::*;
#(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == 2'd0);
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count_reg != 2'd2) || do_pop);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= !wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rom_axi_burst_rd_slave.sv
// AXI read-only slave in front of a 1-cycle-latency synchronous ROM.
// Beats flow ROM -> in-flight stage -> R output register, with a 2-entry buffer behind it.
module rom_axi_burst_rd_slave
    import rom_axi_burst_rd_slave_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 8,
    parameter int LEN_W     = 4,
    parameter int ROM_AW    = 14,
    parameter int ROM_DEPTH = 2**ROM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              ROM_read,
    output logic              ROM_enable,
    output logic [ROM_AW-1:0] ROM_address,
    input  logic [DATA_W-1:0] ROM_out
);

    localparam int CNT_W  = LEN_W + 1;
    localparam int BEAT_W = DATA_W + 3;

    state_e              state_reg, state_next;
    logic [ID_W-1:0]     id_reg;
    logic [LEN_W-1:0]    len_reg;
    burst_e              burst_reg;
    logic                err_all_reg;
    logic [ADDR_W-1:0]   addr_reg, addr_next, wrap_mask_reg;
    logic [CNT_W-1:0]    issue_cnt_reg;
    logic                inflight_reg, wr_rom_reg, wr_last_reg;
    logic [1:0]          wr_resp_reg;
    logic                rvalid_reg, rlast_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [1:0]          rresp_reg;

    logic                ar_hs, r_hs, issue, beat_dec, beat_rom;
    logic [2:0]          occupancy;
    logic [BEAT_W-1:0]   w_beat, fifo_head, src_beat;
    logic                fifo_empty, fifo_push, fifo_pop, out_load, direct;
    logic [1:0]          fifo_count;

    assign ARREADY = (state_reg == ST_IDLE) && !rst;
    assign ar_hs   = ARVALID && ARREADY;
    assign r_hs    = rvalid_reg && RREADY;

    // Credits cover the output register plus both buffer entries; RREADY is not consulted.
    assign occupancy = {2'b00, rvalid_reg} + {1'b0, fifo_count} + {2'b00, inflight_reg};
    assign issue     = (state_reg == ST_BURST) && (issue_cnt_reg <= {1'b0, len_reg})
                       && (occupancy < 3'd3) && !rst;
    assign beat_dec  = |addr_reg[ADDR_W-1:ROM_AW+2];
    assign beat_rom  = issue && !err_all_reg && !beat_dec;

    assign ROM_read    = beat_rom;
    assign ROM_address = addr_reg[ROM_AW+1:2];
    assign ROM_enable  = inflight_reg && wr_rom_reg;

    always_comb begin
        addr_next = addr_reg + ADDR_W'(4);
        case (burst_reg)
            BURST_FIXED: addr_next = addr_reg;
            BURST_WRAP:  addr_next = (addr_reg & ~wrap_mask_reg)
                                   | ((addr_reg + ADDR_W'(4)) & wrap_mask_reg);
            default:     addr_next = addr_reg + ADDR_W'(4);
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (ar_hs) state_next = ST_BURST;
            ST_BURST: if (r_hs && rlast_reg) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Beats go straight to the output register when it is free and nothing older is queued.
    assign w_beat    = {(wr_rom_reg ? ROM_out : '0), wr_resp_reg, wr_last_reg};
    assign out_load  = !rvalid_reg || r_hs;
    assign fifo_pop  = out_load && !fifo_empty;
    assign direct    = out_load && fifo_empty && inflight_reg;
    assign fifo_push = inflight_reg && !direct;
    assign src_beat  = fifo_empty ? w_beat : fifo_head;

    rom_axi_burst_rd_slave_rd_beat_fifo #(
        .WIDTH(BEAT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (w_beat),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            id_reg        <= '0;
            len_reg       <= '0;
            burst_reg     <= BURST_FIXED;
            err_all_reg   <= 1'b0;
            addr_reg      <= '0;
            wrap_mask_reg <= '0;
            issue_cnt_reg <= '0;
            inflight_reg  <= 1'b0;
            wr_rom_reg    <= 1'b0;
            wr_last_reg   <= 1'b0;
            wr_resp_reg   <= RESP_OKAY;
            rvalid_reg    <= 1'b0;
            rdata_reg     <= '0;
            rresp_reg     <= RESP_OKAY;
            rlast_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (ar_hs) begin
                id_reg        <= ARID;
                len_reg       <= ARLEN;
                burst_reg     <= burst_e'(ARBURST);
                err_all_reg   <= (ARSIZE != SIZE_4B) || (ARBURST == BURST_RSVD)
                                 || ((ARBURST == BURST_WRAP) && !wrap_len_ok(16'(ARLEN)));
                addr_reg      <= ARADDR;
                wrap_mask_reg <= ADDR_W'({ARLEN, 2'b11});
                issue_cnt_reg <= '0;
            end else if (issue) begin
                addr_reg      <= addr_next;
                issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
            end
            inflight_reg <= issue;
            if (issue) begin
                wr_rom_reg  <= beat_rom;
                wr_last_reg <= (issue_cnt_reg == {1'b0, len_reg});
                wr_resp_reg <= err_all_reg ? RESP_SLVERR : (beat_dec ? RESP_DECERR : RESP_OKAY);
            end
            if (out_load) begin
                rvalid_reg <= !fifo_empty || inflight_reg;
                if (!fifo_empty || inflight_reg) begin
                    {rdata_reg, rresp_reg, rlast_reg} <= src_beat;
                end
            end
        end
    end

    assign RID    = id_reg;
    assign RDATA  = rdata_reg;
    assign RRESP  = rresp_reg;
    assign RLAST  = rlast_reg;
    assign RVALID = rvalid_reg;

endmodule

// File: tb/tb_rom_axi_burst_rd_slave.sv
// Directed bench for the ROM AXI read slave: burst-level reference model plus per-cycle compare.
module tb_rom_axi_burst_rd_slave;

    logic        clk;
    logic        rst;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        ROM_read;
    logic        ROM_enable;
    logic [13:0] ROM_address;
    logic [31:0] ROM_out;

    rom_axi_burst_rd_slave #(
        .ADDR_W(32), .DATA_W(32), .ID_W(8), .LEN_W(4), .ROM_AW(14)
    ) dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .ROM_read(ROM_read), .ROM_enable(ROM_enable), .ROM_address(ROM_address), .ROM_out(ROM_out)
    );

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        int          k;
    } beat_t;

    beat_t       exp_q[$];
    int          addr_q[$];
    int          addr_log[$];
    beat_t       cmp_b;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ar_cyc = 0;
    int          last_hs_cyc = 0;
    int          hs_cnt = 0;
    int          rmode = 0;
    bit          lat_on = 0;
    bit          stall_prev = 0;
    bit          prev_read = 0;
    logic [31:0] sv_data;
    logic [1:0]  sv_resp;
    logic        sv_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [13:0] w);
        return {2'b10, w, 2'b01, w};
    endfunction

    always @(posedge clk) begin
        if (ROM_read) ROM_out <= rom_word(ROM_address);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // Burst-level model: expected beats and ROM word addresses from the AXI rules.
    task automatic model_push(input logic [7:0] id, input logic [31:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst);
        bit          err_all;
        logic [31:0] a, base, sz;
        beat_t       b;
        err_all = (size != 3'd2) || (burst == 2'd3) ||
                  (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        a  = addr;
        sz = 32'((len + 1) * 4);
        for (int k = 0; k <= len; k++) begin
            b.id   = id;
            b.k    = k;
            b.last = (k == len);
            b.resp = err_all ? 2'd2 : ((a >= 32'h10000) ? 2'd3 : 2'd0);
            b.data = (b.resp == 2'd0) ? rom_word(a[15:2]) : 32'd0;
            if (b.resp == 2'd0) addr_q.push_back(int'(a[15:2]));
            exp_q.push_back(b);
            if (burst == 2'd2) begin
                base = a - (a % sz);
                a    = base + ((a + 32'd4 - base) % sz);
            end else if (burst != 2'd0) begin
                a = a + 32'd4;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
            stall_prev = 0;
            prev_read  = 0;
        end else begin
            if (ROM_enable) chk("rom_enable_after_read", 32'(prev_read), 32'd1);
            if (ROM_read) begin
                addr_log.push_back(int'(ROM_address));
                if (addr_q.size() == 0) chk("rom_read_unexpected", 32'(ROM_read), 32'd0);
                else chk("rom_address", 32'(ROM_address), 32'(addr_q.pop_front()));
            end
            prev_read = ROM_read;
            if (stall_prev) begin
                chk("stall_rvalid", 32'(RVALID), 32'd1);
                chk("stall_rdata", RDATA, sv_data);
                chk("stall_rresp", 32'(RRESP), 32'(sv_resp));
                chk("stall_rlast", 32'(RLAST), 32'(sv_last));
            end
            if (RVALID) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(RVALID), 32'd0);
                end else if (RREADY) begin
                    cmp_b = exp_q.pop_front();
                    chk("rid", 32'(RID), 32'(cmp_b.id));
                    chk("rdata", RDATA, cmp_b.data);
                    chk("rresp", 32'(RRESP), 32'(cmp_b.resp));
                    chk("rlast", 32'(RLAST), 32'(cmp_b.last));
                    if (lat_on) chk("beat_latency", 32'(cyc), 32'(ar_cyc + 3 + cmp_b.k));
                    hs_cnt++;
                    if (RLAST) last_hs_cyc = cyc;
                end
            end
            stall_prev = RVALID && !RREADY;
            sv_data = RDATA;
            sv_resp = RRESP;
            sv_last = RLAST;
        end
    end

    initial begin
        int ridx = 0;
        RREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) RREADY = 1'b1;
            else RREADY = ((ridx % 4) == 0) || ((ridx % 4) == 3);
            ridx++;
        end
    end

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        @(posedge clk);
        #1;
        ARID = id; ARADDR = addr; ARLEN = len[3:0]; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        @(negedge clk);
        while (!ARREADY && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!ARREADY) begin
            chk("ar_timeout", 32'(ARREADY), 32'd1);
            ARVALID = 1'b0;
        end else begin
            model_push(id, addr, len, size, burst);
            ar_cyc = cyc;
            addr_log.delete();
            @(posedge clk);
            #1 ARVALID = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("burst_drained", 32'(exp_q.size()), 32'd0);
        chk("rom_reads_done", 32'(addr_q.size()), 32'd0);
    endtask

    task automatic check_log(input string name, input int n, input int a0, input int a1,
                             input int a2, input int a3);
        int want[4];
        want = '{a0, a1, a2, a3};
        chk({name, "_count"}, 32'(addr_log.size()), 32'(n));
        for (int i = 0; i < n && i < addr_log.size(); i++) chk(name, 32'(addr_log[i]), 32'(want[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        rst = 1'b1; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("arready_in_reset", 32'(ARREADY), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_arready", 32'(ARREADY), 32'd1);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        chk("rst_rlast", 32'(RLAST), 32'd0);
        chk("rst_rid", 32'(RID), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_rresp", 32'(RRESP), 32'd0);
        chk("rst_rom_read", 32'(ROM_read), 32'd0);
        chk("rst_rom_enable", 32'(ROM_enable), 32'd0);
        chk("rst_rom_address", 32'(ROM_address), 32'd0);

        lat_on = 1;
        send_ar(8'd1, 32'h100, 3, 3'd2, 2'd1);
        wait_done();
        check_log("incr_addr", 4, 'h40, 'h41, 'h42, 'h43);

        send_ar(8'd2, 32'h10C, 3, 3'd2, 2'd2);
        wait_done();
        check_log("wrap_addr", 4, 'h43, 'h40, 'h41, 'h42);

        send_ar(8'd3, 32'h20, 2, 3'd2, 2'd0);
        wait_done();
        check_log("fixed_addr", 3, 'h08, 'h08, 'h08, 0);

        lat_on = 0;
        rmode  = 1;
        send_ar(8'd4, 32'h200, 15, 3'd2, 2'd1);
        wait_done();
        chk("incr16_reads", 32'(addr_log.size()), 32'd16);
        rmode = 0;

        send_ar(8'd9, 32'h40, 1, 3'd1, 2'd1);
        wait_done();
        chk("slverr_no_rom", 32'(addr_log.size()), 32'd0);

        send_ar(8'd10, 32'hFFFC, 1, 3'd2, 2'd1);
        wait_done();
        check_log("decerr_addr", 1, 'h3FFF, 0, 0, 0);

        send_ar(8'd11, 32'h40, 2, 3'd2, 2'd2);
        wait_done();
        send_ar(8'd12, 32'h40, 0, 3'd2, 2'd3);
        wait_done();
        chk("bad_burst_no_rom", 32'(addr_log.size()), 32'd0);

        base = hs_cnt;
        send_ar(8'd13, 32'h300, 7, 3'd2, 2'd1);
        t = 0;
        while (hs_cnt < base + 2 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("pre_reset_beats", 32'(hs_cnt - base), 32'd2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_rvalid", 32'(RVALID), 32'd0);
        chk("midrst_arready", 32'(ARREADY), 32'd1);
        send_ar(8'd5, 32'h400, 1, 3'd2, 2'd1);
        wait_done();

        lat_on = 1;
        send_ar(8'd6, 32'h80, 1, 3'd2, 2'd1);
        send_ar(8'd7, 32'h90, 0, 3'd2, 2'd1);
        chk("b2b_gap", 32'(ar_cyc - last_hs_cyc), 32'd1);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
